// File: rtl/aes_bram_pkg.sv
// Shared definitions for the S-box table writer and its checksum helper.
//   state_e      : writer FSM states
//   DEF_*        : default table geometry and BRAM read latency
//   CSUM_*_W     : widths of the XOR and modular-sum checksum fields
package aes_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_RD_LAT = 2;

  localparam int CSUM_XOR_W = 8;
  localparam int CSUM_SUM_W = 16;

endpackage

// File: rtl/table_checksum.sv
// Running checksum over a stream of table entries: 8-bit XOR plus 16-bit
// modular sum. clr_i has priority over acc_i.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : zero both fields
//   acc_i       : fold data_i into both fields
//   data_i      : table entry
//   xor_o/sum_o : current checksum fields
module table_checksum
  import aes_bram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  acc_i,
  input  logic [DATA_W-1:0]     data_i,
  output logic [CSUM_XOR_W-1:0] xor_o,
  output logic [CSUM_SUM_W-1:0] sum_o
);

  logic [CSUM_XOR_W-1:0] xor_q;
  logic [CSUM_SUM_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
      sum_q <= '0;
    end else if (clr_i) begin
      xor_q <= '0;
      sum_q <= '0;
    end else if (acc_i) begin
      xor_q <= xor_q ^ CSUM_XOR_W'(data_i);
      sum_q <= sum_q + CSUM_SUM_W'(data_i);
    end
  end

  assign xor_o = xor_q;
  assign sum_o = sum_q;

endmodule

// File: rtl/sbox_table_writer.sv
// Streams DEPTH table entries from a valid/ready source into a BRAM at
// addresses 0..DEPTH-1, optionally reads the table back and compares
// checksums.
// Build option: SBOX_TABLE_WRITER_READBACK_EN adds the VERIFY pass, the
// readback checksum and the err flag; without it err is 0 and bram_dout
// is ignored.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   start, abort      : begin a load (IDLE only) / terminate a load
//   s_data/s_valid/s_ready : entry stream from the generator
//   bram_en/we/addr/din/dout : BRAM port, dout valid RD_LAT after address
//   busy, done, err   : not idle / completion pulse / readback mismatch
//   wr_count          : entries written in the current or last load
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start
// ST_WRITE  | accepting entries, one BRAM write per transfer
// ST_VERIFY | reading the table back and summing it
// ST_FINISH | one-cycle done pulse, err evaluated
module sbox_table_writer
  import aes_bram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   wr_count
);

  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  state_e state_q, state_d;

  logic              launch, xfer;
  logic [ADDR_W:0]   wr_count_q;
  logic              bram_en_q, bram_we_q;
  logic [ADDR_W-1:0] bram_addr_q;
  logic [DATA_W-1:0] bram_din_q;
  logic              rd_issue, rd_last;
  logic [ADDR_W-1:0] rd_addr;

  assign launch  = (state_q == ST_IDLE) && start && !abort;
  // Abort blocks the handshake so wr_count freezes on the abort edge.
  assign s_ready = (state_q == ST_WRITE) && !abort;
  assign xfer    = s_ready && s_valid;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_FINISH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (launch) state_d = ST_WRITE;
      ST_WRITE: begin
        if (xfer && (wr_count_q == LAST_IDX)) begin
`ifdef SBOX_TABLE_WRITER_READBACK_EN
          state_d = ST_VERIFY;
`else
          state_d = ST_FINISH;
`endif
        end
      end
      ST_VERIFY: if (rd_last) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count_q  <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      bram_en_q <= 1'b0;
      bram_we_q <= 1'b0;
      if (launch) wr_count_q <= '0;
      if (xfer) begin
        bram_en_q   <= 1'b1;
        bram_we_q   <= 1'b1;
        bram_addr_q <= wr_count_q[ADDR_W-1:0];
        bram_din_q  <= s_data;
        wr_count_q  <= wr_count_q + CNT_ONE;
      end else if (rd_issue) begin
        bram_en_q   <= 1'b1;
        bram_addr_q <= rd_addr;
      end
    end
  end

  assign bram_en   = bram_en_q;
  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign wr_count  = wr_count_q;

`ifdef SBOX_TABLE_WRITER_READBACK_EN
  logic [ADDR_W:0]       rd_cnt_q, acc_cnt_q;
  // Bit k set means a read address was on the port k cycles ago; the tap at
  // RD_LAT marks the cycle bram_dout carries that read's data.
  logic [RD_LAT:0]       rd_pipe_q;
  logic                  rd_acc, mismatch, err_q;
  logic [CSUM_XOR_W-1:0] wr_xor, rd_xor;
  logic [CSUM_SUM_W-1:0] wr_sum, rd_sum;

  assign rd_issue = (state_q == ST_VERIFY) && (rd_cnt_q != DEPTH_CNT) && !abort;
  assign rd_addr  = rd_cnt_q[ADDR_W-1:0];
  assign rd_acc   = rd_pipe_q[RD_LAT];
  assign rd_last  = rd_acc && (acc_cnt_q == LAST_IDX);
  assign mismatch = (wr_xor != rd_xor) || (wr_sum != rd_sum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q  <= '0;
      acc_cnt_q <= '0;
      rd_pipe_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (launch) begin
        rd_cnt_q  <= '0;
        acc_cnt_q <= '0;
        err_q     <= 1'b0;
      end
      if (rd_issue) rd_cnt_q <= rd_cnt_q + CNT_ONE;
      if (rd_acc)   acc_cnt_q <= acc_cnt_q + CNT_ONE;
      if (abort) rd_pipe_q <= '0;
      else       rd_pipe_q <= {rd_pipe_q[RD_LAT-1:0], rd_issue};
      if ((state_q == ST_FINISH) && mismatch) err_q <= 1'b1;
    end
  end

  // The FINISH term lets err show up alongside the done pulse.
  assign err = err_q || ((state_q == ST_FINISH) && mismatch);

  table_checksum #(.DATA_W(DATA_W)) u_wr_csum (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (launch),
    .acc_i  (xfer),
    .data_i (s_data),
    .xor_o  (wr_xor),
    .sum_o  (wr_sum)
  );

  table_checksum #(.DATA_W(DATA_W)) u_rd_csum (
    .clk    (clk),
    .rst_n  (rst),
    .clr_i  (launch),
    .acc_i  (rd_acc),
    .data_i (bram_dout),
    .xor_o  (rd_xor),
    .sum_o  (rd_sum)
  );
`else
  logic unused_dout;

  assign rd_issue    = 1'b0;
  assign rd_addr     = '0;
  assign rd_last     = 1'b0;
  assign err         = 1'b0;
  assign unused_dout = ^bram_dout;
`endif

endmodule

// File: tb/tb_sbox_table_writer.sv
module tb_sbox_table_writer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
`ifdef SBOX_TABLE_WRITER_READBACK_EN
  localparam logic RB = 1'b1;
`else
  localparam logic RB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready, bram_en, bram_we, busy, done, err;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din, bram_dout;
  logic [ADDR_W:0]   wr_count;

  always #5 clk = ~clk;

  sbox_table_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout),
    .busy(busy), .done(done), .err(err), .wr_count(wr_count)
  );

  // BRAM model with two-cycle read latency; optional corruption of entry 17.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd1, rd2;
  logic              corrupt17 = 1'b0;

  always @(posedge clk) begin
    if (bram_en && bram_we) mem[bram_addr] <= bram_din;
    if (bram_en && !bram_we)
      rd1 <= mem[bram_addr] ^ ((corrupt17 && bram_addr == 10'd17) ? 8'h01 : 8'h00);
    rd2 <= rd1;
  end
  assign bram_dout = rd2;

  // Write monitor: contiguous addresses, data = addr[7:0] ^ A5.
  int n_wr = 0, n_acc = 0, n_done = 0, addr_bad = 0, data_bad = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  always @(negedge clk) begin
    if (bram_en === 1'b1) n_acc++;
    if (bram_en === 1'b1 && bram_we === 1'b1) begin
      if (bram_addr !== exp_addr) addr_bad++;
      if (bram_din !== (bram_addr[7:0] ^ 8'hA5)) data_bad++;
      exp_addr++;
      n_wr++;
    end
    if (done === 1'b1) n_done++;
  end

  int vecs = 0, errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stream(input logic toggle, input int n_xfer, input int start_at, output int cyc);
    int  idx;
    logic hs;
    idx = 0;
    cyc = 0;
    while (idx < n_xfer && cyc < 4*DEPTH) begin
      s_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      s_data  = 8'(idx) ^ 8'hA5;
      start   = (cyc == start_at);
      hs      = s_valid && s_ready;
      @(negedge clk);
      cyc++;
      if (hs) idx++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int w;
    w = 0;
    while (done !== 1'b1 && w < budget) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int cyc, base, dbase, abase;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {26'd0, s_ready, bram_en, bram_we, busy, done, err}, 32'd0);
    check("rst_addr", {22'd0, bram_addr}, 32'd0);
    check("rst_din", {24'd0, bram_din}, 32'd0);
    check("rst_wrcnt", {21'd0, wr_count}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Full load, s_valid held high.
    exp_addr = '0; base = n_wr; dbase = n_done;
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    stream(1'b0, DEPTH, -1, cyc);
    check("full_cycles", cyc, 32'd1024);
    check("ready_drop", {31'd0, s_ready}, 32'd0);
    wait_done(3000);
    check("full_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {30'd0, done, busy}, 32'd0);
    check("full_nwr", n_wr - base, 32'd1024);
    check("full_addr_bad", addr_bad, 32'd0);
    check("full_data_bad", data_bad, 32'd0);
    check("full_wrcnt", {21'd0, wr_count}, 32'd1024);
    check("full_ndone", n_done - dbase, 32'd1);

    // Toggled s_valid, plus a start pulse while busy.
    exp_addr = '0; base = n_wr; dbase = n_done;
    pulse_start();
    stream(1'b1, DEPTH, 100, cyc);
    check("tog_cycles", cyc, 32'd2047);
    wait_done(3000);
    @(negedge clk);
    check("tog_nwr", n_wr - base, 32'd1024);
    check("tog_addr_bad", addr_bad, 32'd0);
    check("tog_data_bad", data_bad, 32'd0);
    check("tog_wrcnt", {21'd0, wr_count}, 32'd1024);
    check("tog_ndone", n_done - dbase, 32'd1);

    // Abort after 300 transfers.
    exp_addr = '0; base = n_wr; dbase = n_done;
    pulse_start();
    stream(1'b0, 300, -1, cyc);
    abort = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; s_valid = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_wrcnt", {21'd0, wr_count}, 32'd300);
    repeat (5) @(negedge clk);
    check("abort_nwr", n_wr - base, 32'd300);
    check("abort_ndone", n_done - dbase, 32'd0);
    check("abort_wrcnt_hold", {21'd0, wr_count}, 32'd300);

    // start and abort together in IDLE.
    abase = n_acc;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("sa_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("sa_no_access", n_acc - abase, 32'd0);

    // Reset in the middle of WRITE at address 500.
    exp_addr = '0;
    pulse_start();
    stream(1'b0, 500, -1, cyc);
    #2 rst = 1'b0;
    #1;
    check("mrst_ctrl", {27'd0, s_ready, bram_en, bram_we, busy, done}, 32'd0);
    check("mrst_addr", {22'd0, bram_addr}, 32'd0);
    check("mrst_din", {24'd0, bram_din}, 32'd0);
    check("mrst_wrcnt", {21'd0, wr_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    base = n_wr; s_valid = 1'b1;
    repeat (4) @(negedge clk);
    s_valid = 1'b0;
    check("mrst_no_write", n_wr - base, 32'd0);
    check("mrst_idle", {31'd0, busy}, 32'd0);
    exp_addr = '0; base = n_wr; dbase = n_done;
    pulse_start();
    stream(1'b0, DEPTH, -1, cyc);
    wait_done(3000);
    @(negedge clk);
    check("restart_nwr", n_wr - base, 32'd1024);
    check("restart_addr_bad", addr_bad, 32'd0);
    check("restart_wrcnt", {21'd0, wr_count}, 32'd1024);

    // Corrupted readback of entry 17.
    corrupt17 = 1'b1;
    exp_addr = '0;
    pulse_start();
    stream(1'b0, DEPTH, -1, cyc);
    wait_done(3000);
    check("err_at_done", {31'd0, err}, {31'd0, RB});
    @(negedge clk);
    check("err_held1", {31'd0, err}, {31'd0, RB});
    repeat (3) @(negedge clk);
    check("err_held2", {31'd0, err}, {31'd0, RB});
    corrupt17 = 1'b0;
    pulse_start();
    check("err_cleared", {31'd0, err}, 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("err_abort_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/sbox_table_writer.md
SBOX_TABLE_WRITER -- requirements
Module: sbox_table_writer

Interface
REQ-001 Parameter ADDR_W, default 10, table address width.
REQ-002 Parameter DATA_W, default 8, table entry width.
REQ-003 Parameter DEPTH, default 1024, number of entries written per load.
REQ-004 Parameter RD_LAT, default 2, BRAM read latency in cycles (output register enabled).
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous active-low reset.
REQ-007 start  input  1  begin a load; sampled in IDLE only.
REQ-008 abort  input  1  terminate the current load.
REQ-009 s_data  input  DATA_W  next table entry from the generator.
REQ-010 s_valid  input  1  s_data is valid.
REQ-011 s_ready  output  1  the writer accepts s_data this cycle.
REQ-012 bram_en  output  1  BRAM port enable.
REQ-013 bram_we  output  1  BRAM write enable.
REQ-014 bram_addr  output  ADDR_W  BRAM port address.
REQ-015 bram_din  output  DATA_W  BRAM write data.
REQ-016 bram_dout  input  DATA_W  BRAM read data, valid RD_LAT cycles after the read address.
REQ-017 busy  output  1  the FSM is not in IDLE.
REQ-018 done  output  1  one-cycle pulse when a load completes.
REQ-019 err  output  1  readback mismatch flag, held until the next start.
REQ-020 wr_count  output  ADDR_W+1  number of entries written in the current or last load.

Function
REQ-021 The FSM SHALL have the states IDLE, WRITE, VERIFY and FINISH.
REQ-022 In IDLE, start=1 with abort=0 SHALL move the FSM to WRITE, clear wr_count, clear err and clear the checksums.
REQ-023 In WRITE, s_ready SHALL be 1, and a transfer SHALL occur when s_valid and s_ready are both 1.
REQ-024 On each transfer, the writer SHALL, in the next cycle, drive bram_en=1, bram_we=1, bram_addr=wr_count, bram_din=s_data, and increment wr_count.
REQ-025 With no transfer, bram_we SHALL be 0 and bram_en SHALL be 0.
REQ-026 The transfer that writes address DEPTH-1 SHALL end WRITE: the FSM goes to VERIFY if readback is compiled in, otherwise to FINISH.
REQ-027 During WRITE, s_ready SHALL drop in the cycle after the last transfer; addresses SHALL never wrap.
REQ-028 VERIFY SHALL issue one read per cycle (bram_en=1, bram_we=0) for addresses 0..DEPTH-1.
REQ-029 VERIFY SHALL accumulate bram_dout RD_LAT cycles after each read address.
REQ-030 VERIFY SHALL go to FINISH after the last read datum has been accumulated.
REQ-031 FINISH SHALL pulse done=1 for one cycle and then return to IDLE.
REQ-032 If the readback checksum differs from the write checksum, FINISH SHALL set err=1.
REQ-033 Each checksum SHALL be an 8-bit XOR of all entries plus a 16-bit modular sum of all entries.
REQ-034 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge.
REQ-035 On abort, bram_we SHALL be 0 from that edge on, done SHALL not pulse, and wr_count SHALL hold its value.
REQ-036 If start and abort are both 1 in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-037 start SHALL be ignored while busy=1.
REQ-038 busy SHALL equal (state != IDLE).

Reset
REQ-039 rst=0 SHALL immediately force IDLE and set s_ready, bram_en, bram_we, bram_addr, bram_din, busy, done, err and wr_count to 0.
REQ-040 Reset in mid-load SHALL discard the load; after reset release, no write SHALL occur until a new start.

Configuration
REQ-041 With macro SBOX_TABLE_WRITER_READBACK_EN defined, the VERIFY state, the readback checksum and err SHALL be implemented.
REQ-042 Without SBOX_TABLE_WRITER_READBACK_EN, VERIFY SHALL be absent, WRITE SHALL go directly to FINISH, err SHALL be tied to 0, and bram_dout SHALL be unused.

Structure
REQ-043 Shared package aes_bram_pkg SHALL hold the FSM state enum, the default ADDR_W, DATA_W, DEPTH and RD_LAT values, and the checksum width constants.
REQ-044 The checksum (XOR plus sum, with clear and accumulate inputs) SHALL be the sub-module table_checksum, instantiated twice (write path and readback path).

Verification
REQ-045 Full load with s_valid held at 1, data = address[7:0] ^ 8'hA5 -> 1024 writes at addresses 0..1023, wr_count=1024, done pulses once, err=0.
REQ-046 s_valid toggled 1/0 every cycle -> writes occur only on handshake cycles, addresses stay contiguous with no gaps or repeats, and the total load takes about 2048 cycles plus the verify phase.
REQ-047 abort asserted after 300 transfers -> FSM in IDLE on the next edge, no further bram_we, wr_count=300, no done pulse.
REQ-048 With READBACK_EN, the BRAM model corrupts address 17 (bit 0 flipped) -> err=1 at done and held until the next start, which clears it.
REQ-049 rst pulled low during WRITE at address 500 -> all outputs 0 asynchronously; after release, start restarts the load at address 0.
REQ-050 start and abort high together in IDLE -> busy stays 0 and no BRAM access occurs; start pulsed while busy -> ignored, the load completes normally.
